uart_rx_frame_ctrl: RTL and testbench

Frame controller that sits behind the `uart_rx` byte receiver. It drains received bytes through the `rx_data`/`rx_data_valid`/`rx_data_ready` handshake and parses them into framed packets: sync, length, payload, XOR checksum. Payload bytes are buffered speculatively in a FIFO and released to the downstream consumer only after the checksum passes. Bad, oversized, overflowing or stalled frames are rolled back and reported.

---
 rtl/uart_rx_frame_pkg.sv | 30 +++
 rtl/uart_rx_frame_ctrl_if.sv | 37 +++
 rtl/uart_rx_frame_ctrl_fifo.sv | 75 +++++++
 rtl/uart_rx_frame_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_frame_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_pkg
// Shared definitions for the UART frame controller:
//   rx_state_t      parser state encoding (also exported as a debug output)
//   ERR_*           err_code values reported with frame_err
//   timeout_cycles  inter-byte timeout expressed in clock cycles
// ---------------------------------------------------------------------------
package uart_rx_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CSUM    = 3'd3,
        ST_DISCARD = 3'd4
    } rx_state_t;

    localparam logic [1:0] ERR_LEN  = 2'd0;
    localparam logic [1:0] ERR_CSUM = 2'd1;
    localparam logic [1:0] ERR_OVF  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    // Bit periods -> clock cycles (integer cycles per bit, truncated).
    function automatic int timeout_cycles(input int clk_fre_mhz,
                                          input int baud_rate,
                                          input int bits);
        return bits * ((clk_fre_mhz * 1000000) / baud_rate);
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl_if
// Bundles the byte-input handshake (from uart_rx), the payload output
// stream and the frame status signals of uart_rx_frame_ctrl.
//
// Handshake semantics (both streams): a transfer happens on every rising
// clk edge where valid && ready are both high. A source holding valid high
// keeps its data stable until the transfer; ready may change freely.
//
// Modports:
//   master : environment side (drives byte_*, out_ready)
//   slave  : the frame controller
// ---------------------------------------------------------------------------
interface uart_rx_frame_ctrl_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    modport master (
        output byte_data, byte_valid, out_ready,
        input  byte_ready, out_data, out_last, out_valid,
               frame_ok, frame_err, err_code
    );

    modport slave (
        input  byte_data, byte_valid, out_ready,
        output byte_ready, out_data, out_last, out_valid,
               frame_ok, frame_err, err_code
    );
endinterface

// File: rtl/uart_rx_frame_ctrl_fifo.sv
// ---------------------------------------------------------------------------
// rx_frame_fifo
// Payload FIFO with speculative writes. Entries are 9 bits {last, data}.
// Writes advance wr_spec only; commit publishes them by copying wr_spec
// into wr_ptr, rollback discards them by copying wr_ptr back into wr_spec.
// The read side only ever compares against wr_ptr, so uncommitted bytes
// are invisible to the consumer.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   wr_en       write wr_data at wr_spec
//   wr_data     {last, data}
//   commit      wr_ptr <= wr_spec
//   rollback    wr_spec <= wr_ptr (takes priority over wr_en)
//   rd_en       pop the head entry when rd_valid
//   rd_valid    committed data present
//   rd_data     head entry (fall-through)
//   free        DEPTH minus committed occupancy
// ---------------------------------------------------------------------------
module rx_frame_fifo #(
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [8:0]  wr_data,
    input  logic        commit,
    input  logic        rollback,
    input  logic        rd_en,
    output logic        rd_valid,
    output logic [8:0]  rd_data,
    output logic [AW:0] free
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [8:0]  mem [DEPTH];
    logic [AW:0] wr_spec;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_spec[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_spec <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            if (rollback) begin
                wr_spec <= wr_ptr;
            end else if (wr_en) begin
                wr_spec <= wr_spec + 1'b1;
            end
            if (commit) begin
                wr_ptr <= wr_spec;
            end
            // Read pointer is independent of commit/rollback so a pop in
            // the same cycle always takes effect.
            if (rd_en && rd_valid) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign rd_valid = (rd_ptr != wr_ptr);
    assign rd_data  = mem[rd_ptr[AW-1:0]];
    assign free     = DEPTH_W - (wr_ptr - rd_ptr);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl
// Parses bytes from uart_rx into frames: SYNC_BYTE, length L, L payload
// bytes, XOR checksum (L ^ payload). Payload is buffered speculatively and
// released downstream only once the checksum matches; bad, oversized,
// overflowing or (optionally) stalled frames are rolled back and reported.
//
// Optional feature macro: UART_RX_FRAME_TIMEOUT_EN
//   defined   : inter-byte timeout aborts a frame with err_code TMO
//   undefined : no timeout counter, a stalled frame waits indefinitely
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         uart_rx_frame_ctrl_if.slave
//               byte_data/byte_valid/byte_ready : input byte stream
//               out_data/out_last/out_valid/out_ready : payload stream
//               frame_ok/frame_err : one-cycle status pulses
//               err_code : last error type, held until the next error
//   state_dbg   current parser state
// ---------------------------------------------------------------------------
module uart_rx_frame_ctrl
    import uart_rx_frame_pkg::*;
#(
    parameter int         CLK_FRE      = 50,
    parameter int         BAUD_RATE    = 115200,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 32,
    parameter int         FIFO_DEPTH   = 64,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_rx_frame_ctrl_if.slave   bus,
    output rx_state_t             state_dbg
);

    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int TMO_CYCLES = timeout_cycles(CLK_FRE, BAUD_RATE, TIMEOUT_BITS);

    if (MAX_LEN < 1 || MAX_LEN > 255 || FIFO_DEPTH < MAX_LEN ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TMO_CYCLES < 1) begin : g_bad_cfg
        $error("uart_rx_frame_ctrl: invalid parameter set");
    end

    rx_state_t   state;
    logic [7:0]  csum;
    logic [7:0]  rem;
    logic [8:0]  disc_cnt;
    logic        byte_ready_q;
    logic        frame_ok_q;
    logic        frame_err_q;
    logic [1:0]  err_code_q;

    logic        accept;
    logic        csum_match;
    logic        fifo_wr;
    logic        fifo_commit;
    logic        fifo_rollback;
    logic        tmo_hit;
    logic        fifo_rd_valid;
    logic [8:0]  fifo_rd_data;
    logic [AW:0] fifo_free;

    assign accept     = bus.byte_valid && byte_ready_q;
    assign csum_match = (bus.byte_data == csum);

    // FIFO control is combinational so pointers move on the same edge that
    // accepts the byte driving the decision.
    always_comb begin
        fifo_wr       = accept && (state == ST_PAYLOAD);
        fifo_commit   = accept && (state == ST_CSUM) && csum_match;
        fifo_rollback = (accept && (state == ST_CSUM) && !csum_match) || tmo_hit;
    end

`ifdef UART_RX_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // Counts idle cycles inside a frame; fires on the TMO_CYCLES-th one.
    assign tmo_hit = (state != ST_IDLE) && !accept &&
                     (tmo_cnt == TW'(TMO_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_IDLE || accept || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            csum         <= 8'h00;
            rem          <= 8'h00;
            disc_cnt     <= 9'd0;
            byte_ready_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= ERR_LEN;
        end else begin
            byte_ready_q <= 1'b1;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            if (tmo_hit) begin
                state       <= ST_IDLE;
                frame_err_q <= 1'b1;
                err_code_q  <= ERR_TMO;
            end else if (accept) begin
                case (state)
                    ST_IDLE: begin
                        if (bus.byte_data == SYNC_BYTE) begin
                            state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        csum <= bus.byte_data;
                        if (bus.byte_data == 8'h00 || int'(bus.byte_data) > MAX_LEN) begin
                            state       <= ST_IDLE;
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_LEN;
                        end else if (int'(bus.byte_data) > int'(fifo_free)) begin
                            // Payload plus checksum byte are swallowed.
                            state       <= ST_DISCARD;
                            disc_cnt    <= {1'b0, bus.byte_data} + 9'd1;
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_OVF;
                        end else begin
                            state <= ST_PAYLOAD;
                            rem   <= bus.byte_data;
                        end
                    end
                    ST_PAYLOAD: begin
                        csum <= csum ^ bus.byte_data;
                        rem  <= rem - 8'd1;
                        if (rem == 8'd1) begin
                            state <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        state <= ST_IDLE;
                        if (csum_match) begin
                            frame_ok_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                            err_code_q  <= ERR_CSUM;
                        end
                    end
                    ST_DISCARD: begin
                        disc_cnt <= disc_cnt - 9'd1;
                        if (disc_cnt == 9'd1) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    rx_frame_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (fifo_wr),
        .wr_data  ({rem == 8'd1, bus.byte_data}),
        .commit   (fifo_commit),
        .rollback (fifo_rollback),
        .rd_en    (bus.out_ready),
        .rd_valid (fifo_rd_valid),
        .rd_data  (fifo_rd_data),
        .free     (fifo_free)
    );

    // Data is forced to zero when nothing is visible so the read side never
    // shows stale or uninitialised RAM contents.
    assign bus.byte_ready = byte_ready_q;
    assign bus.out_valid  = fifo_rd_valid;
    assign bus.out_data   = fifo_rd_valid ? fifo_rd_data[7:0] : 8'h00;
    assign bus.out_last   = fifo_rd_valid & fifo_rd_data[8];
    assign bus.frame_ok   = frame_ok_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.err_code   = err_code_q;
    assign state_dbg      = state;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;
    import uart_rx_frame_pkg::*;

    localparam logic [7:0] SYNC    = 8'hA5;
    localparam int         MAX_LEN = 32;

    // ---------------- clock / reset ----------------
    logic      clk   = 1'b0;
    logic      rst_n = 1'b0;
    rx_state_t state_dbg;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl_if bus();

    uart_rx_frame_ctrl #(
        .CLK_FRE      (50),
        .BAUD_RATE    (115200),
        .SYNC_BYTE    (SYNC),
        .MAX_LEN      (MAX_LEN),
        .FIFO_DEPTH   (64),
        .TIMEOUT_BITS (20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- bookkeeping ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    int         ok_cnt   = 0;
    int         err_cnt  = 0;
    int         pop_cnt  = 0;
    logic [1:0] last_err = 2'd0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_item;
    logic [7:0] pay[256];
    logic       prev_stall = 1'b0;
    logic [8:0] prev_out   = 9'd0;

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.frame_ok) ok_cnt++;
            if (bus.frame_err) begin
                err_cnt++;
                last_err = bus.err_code;
            end
            if (prev_stall) begin
                n_checks++;
                if ({bus.out_valid, bus.out_last, bus.out_data} !== {1'b1, prev_out}) begin
                    n_fail++;
                    $display("FAIL hold_stable: got v=%0b l=%0b d=%02h, required v=1 l=%0b d=%02h",
                             bus.out_valid, bus.out_last, bus.out_data, prev_out[8], prev_out[7:0]);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got l=%0b d=%02h, required no output",
                             bus.out_last, bus.out_data);
                end else begin
                    exp_item = exp_q.pop_front();
                    pop_cnt++;
                    if ({bus.out_last, bus.out_data} !== exp_item) begin
                        n_fail++;
                        $display("FAIL sb_data: got l=%0b d=%02h, required l=%0b d=%02h",
                                 bus.out_last, bus.out_data, exp_item[8], exp_item[7:0]);
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.out_last, bus.out_data};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) pay[i] = 8'($urandom_range(0, 255));
    endtask

    // Sends SYNC, len, pay[0..len-1], checksum; queues expected output.
    task automatic send_frame(input int len);
        logic [7:0] cs;
        cs = 8'(len);
        send_byte(SYNC);
        send_byte(8'(len));
        for (int i = 0; i < len; i++) begin
            cs = cs ^ pay[i];
            exp_q.push_back({(i == len - 1), pay[i]});
            send_byte(pay[i]);
        end
        send_byte(cs);
    endtask

    task automatic wait_drain(input int max_cycles);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && c < max_cycles) begin
            step(1);
            c++;
        end
        n_checks++;
        if (exp_q.size() != 0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, out_valid=%0b, required 0 pending, out_valid=0",
                     exp_q.size(), bus.out_valid);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n          = 1'b0;
        bus.byte_data  = 8'h00;
        bus.byte_valid = 1'b0;
        bus.out_ready  = 1'b0;
        step(2);
        n_checks++;
        if ({bus.byte_ready, bus.out_valid, bus.out_last, bus.out_data,
             bus.frame_ok, bus.frame_err, bus.err_code} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got r=%0b v=%0b l=%0b d=%02h ok=%0b err=%0b code=%0d, required all 0",
                     bus.byte_ready, bus.out_valid, bus.out_last, bus.out_data,
                     bus.frame_ok, bus.frame_err, bus.err_code);
        end
        n_checks++;
        if (state_dbg !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, required %0d", state_dbg, ST_IDLE);
        end
        rst_n = 1'b1;
        step(1);
        n_checks++;
        if (bus.byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL byte_ready_after_reset: got %0b, required 1", bus.byte_ready);
        end
    endtask

    task automatic test_good_frame();
        int ok0, err0;
        bus.out_ready = 1'b1;
        ok0 = ok_cnt; err0 = err_cnt;
        send_byte(8'h00);   // noise before sync is dropped
        send_byte(8'h33);
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        send_frame(3);      // checksum byte computed as 03
        n_checks++;
        if (bus.frame_ok !== 1'b1 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL commit_cycle: got frame_ok=%0b out_valid=%0b, required 1 1",
                     bus.frame_ok, bus.out_valid);
        end
        step(3);
        n_checks++;
        if (ok_cnt != ok0 + 1 || err_cnt != err0) begin
            n_fail++;
            $display("FAIL good_frame_status: got ok=%0d err=%0d, required ok=%0d err=%0d",
                     ok_cnt - ok0, err_cnt - err0, 1, 0);
        end
        wait_drain(50);
    endtask

    task automatic test_bad_csum();
        int ok0, err0;
        ok0 = ok_cnt; err0 = err_cnt;
        send_byte(SYNC); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h00);
        step(3);
        n_checks++;
        if (err_cnt != err0 + 1 || last_err !== ERR_CSUM || ok_cnt != ok0) begin
            n_fail++;
            $display("FAIL bad_csum: got errs=%0d code=%0d oks=%0d, required errs=1 code=1 oks=0",
                     err_cnt - err0, last_err, ok_cnt - ok0);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_csum_hidden: got out_valid=%0b, required 0", bus.out_valid);
        end
        fill_random(5);
        send_frame(5);
        step(2);
        n_checks++;
        if (ok_cnt != ok0 + 1) begin
            n_fail++;
            $display("FAIL after_bad_csum: got oks=%0d, required 1", ok_cnt - ok0);
        end
        wait_drain(50);
    endtask

    task automatic test_len_err();
        int ok0, err0;
        ok0 = ok_cnt; err0 = err_cnt;
        send_byte(SYNC); send_byte(8'h00);
        step(2);
        n_checks++;
        if (err_cnt != err0 + 1 || last_err !== ERR_LEN || state_dbg !== ST_IDLE) begin
            n_fail++;
            $display("FAIL len_zero: got errs=%0d code=%0d state=%0d, required errs=1 code=0 state=0",
                     err_cnt - err0, last_err, state_dbg);
        end
        send_byte(SYNC); send_byte(8'(MAX_LEN + 1));
        step(2);
        n_checks++;
        if (err_cnt != err0 + 2 || last_err !== ERR_LEN || state_dbg !== ST_IDLE) begin
            n_fail++;
            $display("FAIL len_over: got errs=%0d code=%0d state=%0d, required errs=2 code=0 state=0",
                     err_cnt - err0, last_err, state_dbg);
        end
        fill_random(MAX_LEN);
        send_frame(MAX_LEN);  // largest legal length
        step(2);
        n_checks++;
        if (ok_cnt != ok0 + 1 || err_cnt != err0 + 2) begin
            n_fail++;
            $display("FAIL len_max: got oks=%0d errs=%0d, required oks=1 errs=2",
                     ok_cnt - ok0, err_cnt - err0);
        end
        wait_drain(100);
    endtask

    task automatic test_overflow();
        int ok0, err0, pop0;
        bus.out_ready = 1'b0;
        ok0 = ok_cnt; err0 = err_cnt; pop0 = pop_cnt;
        for (int f = 0; f < 2; f++) begin
            fill_random(MAX_LEN);
            send_frame(MAX_LEN);
        end
        send_byte(SYNC); send_byte(8'h01); send_byte(8'h77); send_byte(8'h77);
        step(2);
        n_checks++;
        if (ok_cnt != ok0 + 2 || err_cnt != err0 + 1 || last_err !== ERR_OVF) begin
            n_fail++;
            $display("FAIL overflow_status: got oks=%0d errs=%0d code=%0d, required oks=2 errs=1 code=2",
                     ok_cnt - ok0, err_cnt - err0, last_err);
        end
        n_checks++;
        if (state_dbg !== ST_IDLE) begin
            n_fail++;
            $display("FAIL overflow_discard: got state=%0d, required 0", state_dbg);
        end
        bus.out_ready = 1'b1;
        wait_drain(200);
        n_checks++;
        if (pop_cnt - pop0 != 2 * MAX_LEN) begin
            n_fail++;
            $display("FAIL overflow_count: got %0d bytes, required %0d", pop_cnt - pop0, 2 * MAX_LEN);
        end
    endtask

    task automatic test_timeout();
        int ok0, err0;
        bus.out_ready = 1'b1;
        ok0 = ok_cnt; err0 = err_cnt;
        send_byte(SYNC); send_byte(8'h02); send_byte(8'h11);
        step(10000);
`ifdef UART_RX_FRAME_TIMEOUT_EN
        n_checks++;
        if (err_cnt != err0 + 1 || last_err !== ERR_TMO || state_dbg !== ST_IDLE) begin
            n_fail++;
            $display("FAIL timeout: got errs=%0d code=%0d state=%0d, required errs=1 code=3 state=0",
                     err_cnt - err0, last_err, state_dbg);
        end
        fill_random(4);
        send_frame(4);
`else
        n_checks++;
        if (err_cnt != err0 || state_dbg !== ST_PAYLOAD) begin
            n_fail++;
            $display("FAIL no_timeout: got errs=%0d state=%0d, required errs=0 state=2",
                     err_cnt - err0, state_dbg);
        end
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b1, 8'h22});
        send_byte(8'h22);
        send_byte(8'h31);  // 02 ^ 11 ^ 22
`endif
        step(2);
        n_checks++;
        if (ok_cnt != ok0 + 1) begin
            n_fail++;
            $display("FAIL after_stall: got oks=%0d, required 1", ok_cnt - ok0);
        end
        wait_drain(50);
    endtask

    task automatic test_back_to_back();
        int  ok0, err0;
        bit  done;
        ok0 = ok_cnt; err0 = err_cnt;
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 6; f++) begin
                    int len;
                    len = $urandom_range(1, 8);
                    fill_random(len);
                    send_frame(len);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.out_ready = 1'($urandom_range(0, 1));
                    step(1);
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_drain(100);
        n_checks++;
        if (ok_cnt != ok0 + 6 || err_cnt != err0) begin
            n_fail++;
            $display("FAIL back_to_back: got oks=%0d errs=%0d, required oks=6 errs=0",
                     ok_cnt - ok0, err_cnt - err0);
        end
    endtask

    task automatic test_reset_mid();
        int ok0;
        bus.out_ready = 1'b0;
        fill_random(4);
        send_frame(4);
        send_byte(SYNC); send_byte(8'h05); send_byte(8'h11); send_byte(8'h22);
        rst_n = 1'b0;
        #2;
        exp_q.delete();
        n_checks++;
        if ({bus.byte_ready, bus.out_valid, bus.out_last, bus.out_data,
             bus.frame_ok, bus.frame_err, bus.err_code} !== 15'd0 || state_dbg !== ST_IDLE) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got r=%0b v=%0b d=%02h code=%0d state=%0d, required all 0",
                     bus.byte_ready, bus.out_valid, bus.out_data, bus.err_code, state_dbg);
        end
        step(2);
        rst_n = 1'b1;
        step(2);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset_empty: got out_valid=%0b byte_ready=%0b, required 0 1",
                     bus.out_valid, bus.byte_ready);
        end
        bus.out_ready = 1'b1;
        ok0 = ok_cnt;
        fill_random(3);
        send_frame(3);
        step(2);
        n_checks++;
        if (ok_cnt != ok0 + 1) begin
            n_fail++;
            $display("FAIL after_reset_frame: got oks=%0d, required 1", ok_cnt - ok0);
        end
        wait_drain(50);
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_len_err();
        test_overflow();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
